// File: rtl/alu_issue_seq.sv
// Accumulator issue sequencer that feeds an 8-bit ALU and returns one result beat per instruction.
// Optional ADC support (op 011 with carry-increment cycle) is built when ALU_ISSUE_ADC_EN is defined.
module alu_issue_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  output logic [2:0] alu_opcode,
  output logic [4:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_data,
  input  logic       alu_c,
  input  logic       alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       flag_z,
  output logic       flag_c
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IMM_W  = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_LDI  = 3'b010;
  localparam logic [OP_W-1:0] OP_ADC  = 3'b011;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b100;
  localparam logic [OP_W-1:0] ALU_IDLE = 3'b111;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  instr_t              instr_s;
  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [IMM_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                res_valid_q, res_valid_d;

  assign instr_s = instr;

  // State, accumulator, flags and registered ALU/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      imm_q       <= '0;
      acc_q       <= '0;
      z_q         <= 1'b1;
      c_q         <= 1'b0;
      alu_op_q    <= ALU_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      c_q         <= c_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state and next-output decode; ALU outputs are computed from the next state
  // so they are stable for the entire EXEC/EXEC2 cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    imm_d       = imm_q;
    acc_d       = acc_q;
    z_d         = z_q;
    c_d         = c_q;
    alu_op_d    = ALU_IDLE;
    alu_a_d     = '0;
    alu_b_d     = acc_q;
    res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d  = instr_s.op;
          imm_d = instr_s.imm;
          case (instr_s.op)
            OP_ADD, OP_SUB: state_d = ST_EXEC;
`ifdef ALU_ISSUE_ADC_EN
            OP_ADC:         state_d = ST_EXEC;
`endif
            OP_LDI: begin
              acc_d   = DATA_W'(instr_s.imm);
              z_d     = (instr_s.imm == '0);
              c_d     = 1'b0;
              state_d = ST_RESP;
            end
            OP_CLR: begin
              acc_d   = '0;
              z_d     = 1'b1;
              c_d     = 1'b0;
              state_d = ST_RESP;
            end
            default:        state_d = ST_RESP;
          endcase
        end
      end
      ST_EXEC: begin
        acc_d   = alu_data;
        c_d     = alu_c;
        z_d     = alu_z;
        state_d = ST_RESP;
`ifdef ALU_ISSUE_ADC_EN
        // Carry-in of 1 needs a second ALU pass to add it.
        if ((op_q == OP_ADC) && c_q) begin
          state_d = ST_EXEC2;
        end
`endif
      end
`ifdef ALU_ISSUE_ADC_EN
      ST_EXEC2: begin
        acc_d   = alu_data;
        c_d     = c_q | alu_c;
        z_d     = alu_z;
        state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    alu_b_d = acc_d;
    if (state_d == ST_EXEC) begin
      alu_op_d = (op_d == OP_ADC) ? OP_ADD : op_d;
      alu_a_d  = imm_d;
    end
`ifdef ALU_ISSUE_ADC_EN
    else if (state_d == ST_EXEC2) begin
      alu_op_d = OP_ADD;
      alu_a_d  = IMM_W'(1);
    end
`endif
    res_valid_d = (state_d == ST_RESP);
  end

  assign instr_ready = rst_n && (state_q == ST_IDLE);
  assign alu_opcode  = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = acc_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: behavioural ALU plus an instruction-level accumulator model.
module tb_alu_issue_seq;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [2:0] alu_opcode;
  logic [4:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_data;
  logic       alu_c;
  logic       alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       flag_z;
  logic       flag_c;

  int n_checks = 0;
  int n_errors = 0;

  // Instruction-level model state
  int m_acc;
  bit m_z;
  bit m_c;

  alu_issue_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_data    (alu_data),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: add is b+a, subtract is b-a with carry meaning no borrow.
  always_comb begin
    int ia, ib, r;
    ia = int'(alu_a);
    ib = int'(alu_b);
    r  = 0;
    alu_c = 1'b0;
    if (alu_opcode == 3'b000) begin
      r     = ib + ia;
      alu_c = (r > 255);
    end else if (alu_opcode == 3'b001) begin
      r     = ib - ia;
      alu_c = (ib >= ia);
    end
    alu_data = 8'((r + 256) % 256);
    alu_z    = (alu_data == 8'h00);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one instruction to the model; returns accept-to-res_valid latency in cycles.
  task automatic model_step(input logic [2:0] op, input logic [4:0] imm,
                            output int lat, output bit uses_alu);
    int t;
    lat = 1;
    uses_alu = 1'b0;
    case (op)
      3'b000: begin
        t = m_acc + int'(imm);
        m_c = (t > 255); m_acc = t % 256; lat = 2; uses_alu = 1'b1;
      end
      3'b001: begin
        m_c = (m_acc >= int'(imm)); m_acc = (m_acc - int'(imm) + 256) % 256;
        lat = 2; uses_alu = 1'b1;
      end
      3'b010: begin m_acc = int'(imm); m_c = 1'b0; end
`ifdef ALU_ISSUE_ADC_EN
      3'b011: begin
        t = m_acc + int'(imm) + (m_c ? 1 : 0);
        lat = m_c ? 3 : 2;
        m_c = (t > 255); m_acc = t % 256; uses_alu = 1'b1;
      end
`endif
      3'b100: begin m_acc = 0; m_c = 1'b0; end
      default: ;
    endcase
    if (op inside {3'b000, 3'b001, 3'b010, 3'b100} || (uses_alu && op == 3'b011))
      m_z = (m_acc == 0);
  endtask

  task automatic do_instr(input logic [2:0] op, input logic [4:0] imm, input int hold);
    int lat, cyc, acc_before;
    bit uses_alu;
    logic [7:0] exp_acc;
    logic [2:0] exp_op;
    acc_before = m_acc;
    model_step(op, imm, lat, uses_alu);
    exp_acc = 8'(m_acc);
    exp_op  = (op == 3'b011) ? 3'b000 : op;
    instr_valid = 1'b1;
    instr = {op, imm};
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_errors++; $display("FAIL ready_before_issue op=%0d: got %b want 1", op, instr_ready);
    end
    cyc = 0;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        instr_valid = 1'b0;
        n_checks++;
        if (uses_alu) begin
          if (alu_opcode !== exp_op || alu_a !== imm || alu_b !== 8'(acc_before)) begin
            n_errors++;
            $display("FAIL exec_drive op=%0d: got op=%0d a=%0d b=%0h want op=%0d a=%0d b=%0h",
                     op, alu_opcode, alu_a, alu_b, exp_op, imm, 8'(acc_before));
          end
        end else if (alu_opcode !== 3'b111 || alu_a !== 5'd0) begin
          n_errors++;
          $display("FAIL alu_idle op=%0d: got op=%0d a=%0d want op=7 a=0", op, alu_opcode, alu_a);
        end
      end
    end while (res_valid !== 1'b1 && cyc < 8);
    n_checks++;
    if (cyc != lat) begin
      n_errors++; $display("FAIL latency op=%0d: got %0d want %0d", op, cyc, lat);
    end
    n_checks++;
    if (res_data !== exp_acc || flag_z !== m_z || flag_c !== m_c) begin
      n_errors++;
      $display("FAIL result op=%0d imm=%0d: got %0h z=%b c=%b want %0h z=%b c=%b",
               op, imm, res_data, flag_z, flag_c, exp_acc, m_z, m_c);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_acc || instr_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold op=%0d: got v=%b d=%0h rdy=%b want v=1 d=%0h rdy=0",
                 op, res_valid, res_data, instr_ready, exp_acc);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL resp_release op=%0d: got v=%b rdy=%b want v=0 rdy=1", op, res_valid, instr_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; instr_valid = 1'b0; instr = 8'h00; res_ready = 1'b0;
    #3 rst_n = 1'b0;
    #4;
    n_checks++;
    if (instr_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'h00 ||
        flag_z !== 1'b1 || flag_c !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%0h z=%b c=%b want 0 0 0 1 0",
               instr_ready, res_valid, res_data, flag_z, flag_c);
    end
    n_checks++;
    if (alu_opcode !== 3'b111 || alu_a !== 5'd0 || alu_b !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_alu: got op=%0d a=%0d b=%0h want 7 0 0", alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_errors++; $display("FAIL ready_after_reset: got %b want 1", instr_ready);
    end
    m_acc = 0; m_z = 1'b1; m_c = 1'b0;
  endtask

  task automatic test_add();
    do_instr(3'b000, 5'd5, 0);
  endtask

  task automatic test_sub();
    do_instr(3'b010, 5'd3, 0);
    do_instr(3'b001, 5'd3, 0);
    do_instr(3'b010, 5'd3, 0);
    do_instr(3'b001, 5'd4, 1);
  endtask

  task automatic test_wrap();
    do_instr(3'b010, 5'd0, 0);
    do_instr(3'b001, 5'd1, 0);
    do_instr(3'b000, 5'd1, 0);
  endtask

  task automatic test_adc();
    do_instr(3'b011, 5'd2, 0);
    do_instr(3'b100, 5'd9, 0);
    do_instr(3'b011, 5'd31, 0);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_acc;
    do_instr(3'b010, 5'd9, 0);
    instr_valid = 1'b1;
    instr = {3'b010, 5'd20};
    step();
    m_acc = 20; m_z = 1'b0; m_c = 1'b0;
    instr = {3'b000, 5'd1};
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 8'd20 || instr_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%0h rdy=%b want v=1 d=14 rdy=0",
                 i, res_valid, res_data, instr_ready);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", res_valid, instr_ready);
    end
    step();
    instr_valid = 1'b0;
    n_checks++;
    if (alu_opcode !== 3'b000 || alu_a !== 5'd1 || alu_b !== 8'd20) begin
      n_errors++;
      $display("FAIL bp_pending_exec: got op=%0d a=%0d b=%0h want 0 1 14", alu_opcode, alu_a, alu_b);
    end
    step();
    exp_acc = 8'd21;
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== exp_acc) begin
      n_errors++;
      $display("FAIL bp_pending_result: got v=%b d=%0h want v=1 d=%0h", res_valid, res_data, exp_acc);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    m_acc = 21; m_z = 1'b0; m_c = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [4:0] imm;
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      imm = 5'($urandom);
      do_instr(op, imm, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    do_instr(3'b010, 5'd4, 0);
    instr_valid = 1'b1;
    instr = {3'b000, 5'd7};
    step();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_acc = 0; m_z = 1'b1; m_c = 1'b0;
    n_checks++;
    if (res_data !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b0 ||
        res_valid !== 1'b0 || instr_ready !== 1'b0 || alu_opcode !== 3'b111) begin
      n_errors++;
      $display("FAIL mid_reset: got d=%0h z=%b c=%b v=%b rdy=%b op=%0d want 0 1 0 0 0 7",
               res_data, flag_z, flag_c, res_valid, instr_ready, alu_opcode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (res_valid !== 1'b0 || res_data !== 8'h00 || instr_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL post_reset_idle cycle %0d: got v=%b d=%0h rdy=%b want 0 0 1",
                 i, res_valid, res_data, instr_ready);
      end
    end
    do_instr(3'b000, 5'd7, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_adc();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
